// File: rtl/ram_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: port count, FSM state
// encodings and port index names.
package ram_arb_pkg;

    localparam int NUM_PORTS = 2;

    // FSM encodings (legacy-compatible constants rather than an enum)
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOCK0 = 2'd1;
    localparam logic [1:0] ST_LOCK1 = 2'd2;

    // Port roles
    localparam int P_CPU = 0;
    localparam int P_GFX = 1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way picker. A port is eligible when it requests and its
// mask bit is set. On a tie the port other than 'last' wins, unless
// fixed_prio is set, in which case port 0 always wins.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eligible_s;

    // Resolve eligible requesters into a one-hot grant
    always_comb begin
        eligible_s = req & mask;
        gnt        = 2'b00;
        case (eligible_s)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (fixed_prio) begin
                    gnt = 2'b01;
                end else if (last) begin
                    gnt = 2'b01;
                end else begin
                    gnt = 2'b10;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port negedge-clocked RAM.
// Port 0 is the soft CPU, port 1 the sprite engine. Round-robin between the
// two, with an optional per-port bus lock bounded to LOCK_MAX cycles.
// Read data returns two cycles after the grant with a per-port valid pulse.
// Build option: define RAM_ARB_FIXED_PRIO_EN to make port 0 win every tie.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 12,
    parameter int LOCK_MAX      = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_PORTS-1:0]               req,
    input  logic [NUM_PORTS-1:0]               we,
    input  logic [NUM_PORTS-1:0]               lock,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    wdata,
    output logic [NUM_PORTS-1:0]               gnt,
    output logic [NUM_PORTS-1:0]               rvalid,
    output logic [DATA_WIDTH-1:0]              rdata,
    output logic                               lock_timeout,
    output logic                               ram_wEn,
    output logic [ADDRESS_WIDTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_dataIn,
    input  logic [DATA_WIDTH-1:0]              ram_dataOut
);

    localparam int CNT_W = $clog2(LOCK_MAX);
    // The counter is at this value on the last locked cycle: the edge that
    // ends it would bring the count to LOCK_MAX-1, so the lock is released.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 2);

    logic [1:0]               state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic                     last_grant_r;
    logic [NUM_PORTS-1:0]     block_r;
    logic                     lock_timeout_r;
    logic [NUM_PORTS-1:0]     rd_pend_r;
    logic [NUM_PORTS-1:0]     rvalid_r;
    logic [DATA_WIDTH-1:0]    rdata_r;
    logic                     ram_wen_r;
    logic [ADDRESS_WIDTH-1:0] ram_addr_r;
    logic [DATA_WIDTH-1:0]    ram_din_r;

    logic [NUM_PORTS-1:0]     mask_s;
    logic [NUM_PORTS-1:0]     gnt_s;
    logic                     win_s;
    logic                     any_gnt_s;
    logic                     own_port_s;
    logic                     own_lock_s;
    logic                     fixed_prio_s;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign fixed_prio_s = 1'b1;
`else
    assign fixed_prio_s = 1'b0;
`endif

    assign win_s      = gnt_s[P_GFX];
    assign any_gnt_s  = |gnt_s;
    assign own_port_s = (state_r == ST_LOCK1);
    assign own_lock_s = lock[own_port_s];

    // Which ports may be granted this cycle; nothing is granted in reset
    always_comb begin
        mask_s = 2'b00;
        if (reset_n) begin
            case (state_r)
                ST_IDLE:  mask_s = 2'b11;
                ST_LOCK0: mask_s = 2'b01;
                ST_LOCK1: mask_s = 2'b10;
                default:  mask_s = 2'b00;
            endcase
        end else begin
            mask_s = 2'b00;
        end
    end

    rr_pick2 u_pick (
        .req        (req),
        .last       (last_grant_r),
        .fixed_prio (fixed_prio_s),
        .mask       (mask_s),
        .gnt        (gnt_s)
    );

    assign gnt = gnt_s;

    // Lock FSM, hold counter, round-robin history and relock blocking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            cnt_r          <= {CNT_W{1'b0}};
            last_grant_r   <= 1'b1;
            block_r        <= 2'b00;
            lock_timeout_r <= 1'b0;
        end else begin
            lock_timeout_r <= 1'b0;
            if (any_gnt_s) begin
                last_grant_r <= win_s;
            end
            // A port may relock only after it has dropped lock once
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!lock[k]) begin
                    block_r[k] <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (any_gnt_s && lock[win_s] && !block_r[win_s]) begin
                        state_r <= win_s ? ST_LOCK1 : ST_LOCK0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (!own_lock_s) begin
                        state_r      <= ST_IDLE;
                        cnt_r        <= {CNT_W{1'b0}};
                        last_grant_r <= own_port_s;
                    end else if (cnt_r == CNT_LAST) begin
                        state_r             <= ST_IDLE;
                        cnt_r               <= {CNT_W{1'b0}};
                        lock_timeout_r      <= 1'b1;
                        last_grant_r        <= own_port_s;
                        block_r[own_port_s] <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // RAM command register and two-stage read return pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_wen_r  <= 1'b0;
            ram_addr_r <= {ADDRESS_WIDTH{1'b0}};
            ram_din_r  <= {DATA_WIDTH{1'b0}};
            rd_pend_r  <= 2'b00;
            rvalid_r   <= 2'b00;
            rdata_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            if (any_gnt_s) begin
                ram_wen_r  <= we[win_s];
                ram_addr_r <= win_s ? addr[ADDRESS_WIDTH +: ADDRESS_WIDTH]
                                    : addr[0 +: ADDRESS_WIDTH];
                ram_din_r  <= win_s ? wdata[DATA_WIDTH +: DATA_WIDTH]
                                    : wdata[0 +: DATA_WIDTH];
            end else begin
                ram_wen_r  <= 1'b0;
            end
            rd_pend_r <= gnt_s & ~we;
            rvalid_r  <= rd_pend_r;
            if (|rd_pend_r) begin
                rdata_r <= ram_dataOut;
            end
        end
    end

    assign rvalid       = rvalid_r;
    assign rdata        = rdata_r;
    assign lock_timeout = lock_timeout_r;
    assign ram_wEn      = ram_wen_r;
    assign ram_addr     = ram_addr_r;
    assign ram_dataIn   = ram_din_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural negedge RAM.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req, we, lock;
    logic [23:0] addr;
    logic [63:0] wdata;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata;
    logic        lock_timeout, ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn, ram_dataOut;
    logic [31:0] mem [0:4095];

    int total_cnt = 0;
    int bad_cnt   = 0;

`ifdef RAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .we           (we),
        .lock         (lock),
        .addr         (addr),
        .wdata        (wdata),
        .gnt          (gnt),
        .rvalid       (rvalid),
        .rdata        (rdata),
        .lock_timeout (lock_timeout),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut)
    );

    // Single-port RAM: write on wEn, otherwise register read data
    always @(negedge clk) begin
        if (ram_wEn) mem[ram_addr] <= ram_dataIn;
        else         ram_dataOut   <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs after the posedge, return at the negedge
    task automatic tick(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                        input logic [11:0] a0, input logic [11:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req = r; we = w; lock = l;
        addr = {a1, a0}; wdata = {d1, d0};
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},  {30'd0, gnt},        32'd0);
        check({tag, "_rv"},   {30'd0, rvalid},     32'd0);
        check({tag, "_rd"},   rdata,               32'd0);
        check({tag, "_to"},   {31'd0, lock_timeout}, 32'd0);
        check({tag, "_wen"},  {31'd0, ram_wEn},    32'd0);
        check({tag, "_addr"}, {20'd0, ram_addr},   32'd0);
        check({tag, "_din"},  ram_dataIn,          32'd0);
    endtask

    logic [1:0] t3_req  [5] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b01};
    logic [1:0] t3_lock [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [1:0] t3_gnt  [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b01};

    initial begin
        logic [1:0]  eg, ev, r, l;
        logic [31:0] ed;

        // Reset: requests present but nothing granted, all outputs zero
        reset_n = 1'b0; req = 2'b11; we = 2'b00; lock = 2'b00;
        addr = 24'd0; wdata = 64'd0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        #1;
        reset_n = 1'b1; req = 2'b00;

        // Port 0 write then read back the same word
        tick(2'b01, 2'b01, 2'b00, 12'h010, 12'h000, 32'hDEADBEEF, 32'd0);
        check("t1_gnt_wr", {30'd0, gnt}, 32'h1);
        tick(2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 32'd0, 32'd0);
        check("t1_gnt_rd", {30'd0, gnt}, 32'h1);
        check("t1_wen",    {31'd0, ram_wEn}, 32'h1);
        check("t1_addr",   {20'd0, ram_addr}, 32'h010);
        check("t1_din",    ram_dataIn, 32'hDEADBEEF);
        check("t1_rv0",    {30'd0, rvalid}, 32'h0);
        tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);
        check("t1_rv1",    {30'd0, rvalid}, 32'h0);
        check("t1_wen_rd", {31'd0, ram_wEn}, 32'h0);
        tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);
        check("t1_rv2",    {30'd0, rvalid}, 32'h1);
        check("t1_rdata",  rdata, 32'hDEADBEEF);
        tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);
        check("t1_rv3",    {30'd0, rvalid}, 32'h0);
        check("t1_hold",   rdata, 32'hDEADBEEF);

        // Preload two words, then both ports read back-to-back
        tick(2'b01, 2'b01, 2'b00, 12'h100, 12'h000, 32'h0A0A0A0A, 32'd0);
        check("t2_pre0", {30'd0, gnt}, 32'h1);
        tick(2'b10, 2'b10, 2'b00, 12'h000, 12'h101, 32'd0, 32'h1B1B1B1B);
        check("t2_pre1", {30'd0, gnt}, 32'h2);
        for (int i = 0; i < 8; i++) begin
            r = (i < 6) ? 2'b11 : 2'b00;
            tick(r, 2'b00, 2'b00, 12'h100, 12'h101, 32'd0, 32'd0);
            if (i >= 6)      eg = 2'b00;
            else if (FIXED)  eg = 2'b01;
            else             eg = (i % 2 == 1) ? 2'b10 : 2'b01;
            if (i < 2)       ev = 2'b00;
            else if (FIXED)  ev = 2'b01;
            else             ev = ((i - 2) % 2 == 1) ? 2'b10 : 2'b01;
            ed = (ev == 2'b10) ? 32'h1B1B1B1B : 32'h0A0A0A0A;
            check($sformatf("t2_gnt%0d", i), {30'd0, gnt}, {30'd0, eg});
            check($sformatf("t2_rv%0d", i),  {30'd0, rvalid}, {30'd0, ev});
            if (ev != 2'b00) check($sformatf("t2_rd%0d", i), rdata, ed);
        end

        // Port 1 holds the bus for three accesses while port 0 waits
        for (int i = 0; i < 5; i++) begin
            tick(t3_req[i], 2'b00, t3_lock[i], 12'h100, 12'h101, 32'd0, 32'd0);
            check($sformatf("t3_gnt%0d", i), {30'd0, gnt}, {30'd0, t3_gnt[i]});
            check($sformatf("t3_to%0d", i),  {31'd0, lock_timeout}, 32'h0);
        end
        repeat (2) tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);

        // Port 0 overstays its lock and is forced off; relock needs a toggle
        for (int i = 0; i < 25; i++) begin
            if (i == 0)       r = 2'b01;
            else if (i < 20)  r = 2'b11;
            else if (i < 22)  r = 2'b01;
            else if (i < 24)  r = 2'b11;
            else              r = 2'b10;
            l = (i == 20 || i >= 23) ? 2'b00 : 2'b01;
            tick(r, 2'b00, l, 12'h100, 12'h101, 32'd0, 32'd0);
            if (i <= 15)      eg = 2'b01;
            else if (i < 20)  eg = FIXED ? 2'b01 : ((i % 2 == 0) ? 2'b10 : 2'b01);
            else if (i < 24)  eg = 2'b01;
            else              eg = 2'b10;
            check($sformatf("t4_gnt%0d", i), {30'd0, gnt}, {30'd0, eg});
            check($sformatf("t4_to%0d", i),  {31'd0, lock_timeout}, {31'd0, (i == 16)});
        end
        repeat (2) tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);

        // Reset the cycle after a read grant drops the read
        tick(2'b01, 2'b00, 2'b00, 12'h100, 12'h000, 32'd0, 32'd0);
        check("t5_gnt", {30'd0, gnt}, 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b0; req = 2'b00;
        @(negedge clk);
        check_all_zero("t5a");
        @(negedge clk);
        check("t5b_rv", {30'd0, rvalid}, 32'h0);
        #1;
        reset_n = 1'b1;
        tick(2'b11, 2'b00, 2'b00, 12'h100, 12'h101, 32'd0, 32'd0);
        check("t5_tie", {30'd0, gnt}, 32'h1);
        tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);
        tick(2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 32'd0, 32'd0);
        check("t5_rv", {30'd0, rvalid}, 32'h1);
        check("t5_rd", rdata, 32'h0A0A0A0A);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
